pet2001_tap_player: RTL

- Sequences the PET cassette #1 read path from a TAP image byte stream, so the I/O block's cassette interface can load software without a physical deck.
- Consumes TAP pulse bytes over a valid/ready handshake from the image loader.
- Drives the cassette read line and play-sense switch into the I/O block.
- Honours the motor control coming back out of the PIA.
- Pulse timing counts CPU clock enables (ce), so playback tracks emulated CPU speed.

---
 rtl/pet2001_tap_player.sv | 105 ++++++++++
 1 files changed

// File: rtl/pet2001_tap_player.sv
// pet2001_tap_player: replays a TAP image as the PET cassette #1 read signal.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   ce                CPU clock enable; all pulse timing counts ce cycles
//   tap_v1            TAP version select (0 = v0, 1 = v1), latched on play
//   play, stop        single-cycle session start / abort (stop wins)
//   in_data/in_valid/in_last/in_ready
//                     TAP byte stream from the image loader (valid/ready)
//   cass_motor_n      PIA motor control, 0 = motor running
//   cass_read         emulated tape read line (low during the low phase)
//   cass_sense_n      play-key sense, 0 while a session is active
//   busy              session active
module pet2001_tap_player #(
    parameter int CNT_W = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       tap_v1,
    input  logic       play,
    input  logic       stop,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    input  logic       cass_motor_n,
    output logic       cass_read,
    output logic       cass_sense_n,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, FETCH, EXT0, EXT1, EXT2, LOWPH, HIGHPH} state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, hi, period, low, high;
    logic [15:0]      ext;
    logic             v1, last, last_nx, xfer, tick, ext_go, done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        busy         = (state != IDLE);
        cass_sense_n = (state == IDLE);
        cass_read    = (state != LOWPH);
        in_ready     = (state == FETCH) || (state == EXT0) || (state == EXT1) || (state == EXT2);
        xfer         = in_ready && in_valid;
        // timing only advances while the emulated deck is actually turning
        tick         = ce && !cass_motor_n;
        // the end-of-image flag covers every byte of the current pulse
        last_nx      = (state == FETCH) ? in_last : (last || in_last);
        ext_go       = xfer && (state == FETCH) && (in_data == 8'd0) && v1;
        done         = xfer && ((state == EXT2) || ((state == FETCH) && !ext_go));
        period       = (state == EXT2)     ? CNT_W'({in_data, ext}) :
                       (in_data != 8'd0)   ? CNT_W'({in_data, 3'b000}) :
                                             CNT_W'(12'd2048);
        low          = period >> 1;
        high         = period - low;
        case (state)
            IDLE:    if (play) state_nx = FETCH;
            FETCH:   if (ext_go) state_nx = EXT0;
            EXT0:    if (xfer) state_nx = EXT1;
            EXT1:    if (xfer) state_nx = EXT2;
            LOWPH:   if (tick && cnt == ONE) state_nx = HIGHPH;
            HIGHPH:  if (tick && cnt == ONE) state_nx = last ? IDLE : FETCH;
            default: ;
        endcase
        // a zero period emits nothing; a period of 1 has no low half
        if (done) state_nx = (period == '0) ? (last_nx ? IDLE : FETCH) :
                             (low == '0)    ? HIGHPH : LOWPH;
        if (stop) state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            hi   <= '0;
            ext  <= '0;
            v1   <= 1'b0;
            last <= 1'b0;
        end else if (stop) begin
            cnt  <= '0;
            ext  <= '0;
            last <= 1'b0;
        end else begin
            if (state == IDLE && play) v1 <= tap_v1;
            if (xfer) last <= last_nx;
            if (xfer && state == EXT0) ext[7:0] <= in_data;
            if (xfer && state == EXT1) ext[15:8] <= in_data;
            if (done) begin
                cnt <= (low == '0) ? high : low;
                hi  <= high;
            end else if (tick && state == LOWPH) begin
                cnt <= (cnt == ONE) ? hi : cnt - ONE;
            end else if (tick && state == HIGHPH) begin
                cnt <= cnt - ONE;
            end
        end
    end
endmodule
